// File: rtl/ghost_dist_map_builder.sv
// rtl/ghost_dist_map_builder.sv - BFS distance map from pacman over the wall map, one level per raster pass.
// Optional horizontal wrap-around tunnel: define GHOST_MAP_TUNNEL_EN.
module ghost_dist_map_builder #(
   parameter int GRID_W = 40,
   parameter int GRID_H = 30
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [5:0] curr_pacman_x,
   input  logic [4:0] curr_pacman_y,
   output logic [5:0] wall_rdaddr_x,
   output logic [4:0] wall_rdaddr_y,
   input  logic       wall_data,
   input  logic [5:0] rdaddr_x,
   input  logic [4:0] rdaddr_y,
   output logic [7:0] data,
   output logic       ready
);
   localparam int N  = GRID_W * GRID_H;
   localparam int AW = $clog2(N);

   typedef enum logic [2:0] {IDLE, CLEAR, SEED, SCAN_ADDR, SCAN_EVAL, LEVEL_END, DONE} state_t;

   state_t      r_state;
   logic [7:0]  r_dist [N];
   logic [5:0]  r_px, r_x, r_wall_x;
   logic [4:0]  r_py, r_y, r_wall_y;
   logic [7:0]  r_level, r_data;
   logic        r_changed, r_ready;

   logic [AW-1:0] w_idx_c, w_idx_l, w_idx_r, w_idx_u, w_idx_d, w_idx_pac, w_idx_rd;
   logic          w_has_l, w_has_r, w_has_u, w_has_d, w_nb_hit;
   logic          w_change, w_last, w_pac_ok, w_rd_ok;
   logic [5:0]    w_nx;
   logic [4:0]    w_ny;

   assign w_change  = (curr_pacman_x != r_px) || (curr_pacman_y != r_py);
   assign w_last    = (int'(r_x) == GRID_W - 1) && (int'(r_y) == GRID_H - 1);
   assign w_nx      = (int'(r_x) == GRID_W - 1) ? 6'd0 : r_x + 6'd1;
   assign w_ny      = (int'(r_x) == GRID_W - 1) ? r_y + 5'd1 : r_y;
   assign w_pac_ok  = (int'(r_px) < GRID_W) && (int'(r_py) < GRID_H);
   assign w_rd_ok   = (int'(rdaddr_x) < GRID_W) && (int'(rdaddr_y) < GRID_H);
   assign w_idx_pac = AW'(int'(r_py) * GRID_W + int'(r_px));
   assign w_idx_rd  = AW'(int'(rdaddr_y) * GRID_W + int'(rdaddr_x));

   // Neighbour lookup for the scan cell; only cells already at level L seed, so the scan stays exact BFS.
   always_comb begin
      w_idx_c = AW'(int'(r_y) * GRID_W + int'(r_x));
      w_idx_l = w_idx_c - AW'(1);
      w_idx_r = w_idx_c + AW'(1);
      w_idx_u = w_idx_c - AW'(GRID_W);
      w_idx_d = w_idx_c + AW'(GRID_W);
      w_has_l = (r_x != 6'd0);
      w_has_r = (int'(r_x) != GRID_W - 1);
      w_has_u = (r_y != 5'd0);
      w_has_d = (int'(r_y) != GRID_H - 1);
`ifdef GHOST_MAP_TUNNEL_EN
      if (r_x == 6'd0) begin
         w_idx_l = w_idx_c + AW'(GRID_W - 1);
         w_has_l = 1'b1;
      end
      if (int'(r_x) == GRID_W - 1) begin
         w_idx_r = w_idx_c - AW'(GRID_W - 1);
         w_has_r = 1'b1;
      end
`else
`endif
      w_nb_hit = (w_has_l && r_dist[w_idx_l] == r_level) ||
                 (w_has_r && r_dist[w_idx_r] == r_level) ||
                 (w_has_u && r_dist[w_idx_u] == r_level) ||
                 (w_has_d && r_dist[w_idx_d] == r_level);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ready   <= 1'b0;
         r_data    <= 8'hFF;
         r_wall_x  <= '0;
         r_wall_y  <= '0;
         r_px      <= 6'd63;
         r_py      <= 5'd31;
         r_x       <= '0;
         r_y       <= '0;
         r_level   <= '0;
         r_changed <= 1'b0;
      end else begin
         r_data <= (r_ready && w_rd_ok) ? r_dist[w_idx_rd] : 8'hFF;
         if (r_state == IDLE || w_change) begin
            r_state <= CLEAR;
            r_px    <= curr_pacman_x;
            r_py    <= curr_pacman_y;
            r_x     <= '0;
            r_y     <= '0;
            r_ready <= 1'b0;
         end else begin
            case (r_state)
               CLEAR: begin
                  r_dist[w_idx_c] <= 8'hFF;
                  r_x <= w_nx;
                  r_y <= w_ny;
                  if (w_last) r_state <= SEED;
               end
               SEED: begin
                  r_x       <= '0;
                  r_y       <= '0;
                  r_level   <= '0;
                  r_changed <= 1'b0;
                  if (w_pac_ok) begin
                     r_dist[w_idx_pac] <= 8'd0;
                     r_wall_x <= '0;
                     r_wall_y <= '0;
                     r_state  <= SCAN_ADDR;
                  end else begin
                     r_ready <= 1'b1;
                     r_state <= DONE;
                  end
               end
               SCAN_ADDR: r_state <= SCAN_EVAL;
               SCAN_EVAL: begin
                  if (!wall_data && r_dist[w_idx_c] == 8'hFF && w_nb_hit) begin
                     r_dist[w_idx_c] <= r_level + 8'd1;
                     r_changed <= 1'b1;
                  end
                  if (w_last) begin
                     r_state <= LEVEL_END;
                  end else begin
                     r_x      <= w_nx;
                     r_y      <= w_ny;
                     r_wall_x <= w_nx;
                     r_wall_y <= w_ny;
                     r_state  <= SCAN_ADDR;
                  end
               end
               LEVEL_END: begin
                  if (!r_changed || r_level == 8'd252) begin
                     r_ready <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_level   <= r_level + 8'd1;
                     r_changed <= 1'b0;
                     r_x       <= '0;
                     r_y       <= '0;
                     r_wall_x  <= '0;
                     r_wall_y  <= '0;
                     r_state   <= SCAN_ADDR;
                  end
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign wall_rdaddr_x = r_wall_x;
   assign wall_rdaddr_y = r_wall_y;
   assign data          = r_data;
   assign ready         = r_ready;
endmodule

// File: tb/tb_ghost_dist_map_builder.sv
// tb/tb_ghost_dist_map_builder.sv - bench for ghost_dist_map_builder on a reduced 16x8 grid.
// BFS reference model plus directed literal reads.
module tb_ghost_dist_map_builder;
   localparam int W = 16;
   localparam int H = 8;
   localparam int N = W * H;
   localparam int LIMIT = 20000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] px = 6'd5;
   logic [4:0] py = 5'd3;
   logic [5:0] wall_rdaddr_x;
   logic [4:0] wall_rdaddr_y;
   logic       wall_data = 1'b1;
   logic [5:0] rx = 6'd0;
   logic [4:0] ry = 5'd0;
   logic [7:0] data;
   logic       ready;

   int  tests = 0;
   int  fails = 0;
   bit  walls [W][H];
   int  model [W][H];
   bit  model_valid = 1'b0;
   bit  have_prev = 1'b0;
   bit  p_ready = 1'b0;
   int  p_x = 0, p_y = 0;
   int  wx, wy;
   int  cyc;

   always #10 clk = ~clk;

   ghost_dist_map_builder #(.GRID_W(W), .GRID_H(H)) dut (
      .CLOCK_50(clk), .reset(reset),
      .curr_pacman_x(px), .curr_pacman_y(py),
      .wall_rdaddr_x(wall_rdaddr_x), .wall_rdaddr_y(wall_rdaddr_y), .wall_data(wall_data),
      .rdaddr_x(rx), .rdaddr_y(ry), .data(data), .ready(ready)
   );

   // Wall memory with one-cycle read latency.
   always @(posedge clk) begin
      wx = int'(wall_rdaddr_x);
      wy = int'(wall_rdaddr_y);
      wall_data <= (wx < W && wy < H) ? walls[wx][wy] : 1'b1;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void build_model(input int sx, input int sy);
      int qx[$], qy[$];
      int cx, cy, d, nx, ny;
      for (int x = 0; x < W; x++)
         for (int y = 0; y < H; y++) model[x][y] = 255;
      if (sx >= W || sy >= H) return;
      model[sx][sy] = 0;
      qx.push_back(sx);
      qy.push_back(sy);
      while (qx.size() > 0) begin
         cx = qx.pop_front();
         cy = qy.pop_front();
         d = model[cx][cy];
         if (d >= 253) continue;
         for (int k = 0; k < 4; k++) begin
            nx = cx + ((k == 0) ? -1 : (k == 1) ? 1 : 0);
            ny = cy + ((k == 2) ? -1 : (k == 3) ? 1 : 0);
`ifdef GHOST_MAP_TUNNEL_EN
            if (nx < 0) nx = W - 1;
            else if (nx >= W) nx = 0;
`endif
            if (nx < 0 || nx >= W || ny < 0 || ny >= H) continue;
            if (walls[nx][ny] || model[nx][ny] != 255) continue;
            model[nx][ny] = d + 1;
            qx.push_back(nx);
            qy.push_back(ny);
         end
      end
   endfunction

   // data is checked every cycle against the registered read of the previous cycle.
   always @(negedge clk) begin
      if (have_prev) begin
         if (!p_ready || p_x >= W || p_y >= H)
            check($sformatf("data(%0d,%0d)", p_x, p_y), data, 255);
         else if (model_valid)
            check($sformatf("data(%0d,%0d)", p_x, p_y), data, model[p_x][p_y]);
      end
      p_ready   = ready;
      p_x       = int'(rx);
      p_y       = int'(ry);
      have_prev = !reset;
   end

   task automatic wait_build(input string name, output int n);
      n = 0;
      while (!ready && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready"}, ready, 1);
      build_model(int'(px), int'(py));
      model_valid = 1'b1;
   endtask

   task automatic set_pac(input int x, input int y);
      @(posedge clk);
      #1;
      model_valid = 1'b0;
      px = 6'(x);
      py = 5'(y);
   endtask

   task automatic rebuild(input string name, input int x, input int y, output int n);
      set_pac(x, y);
      @(posedge clk);
      @(negedge clk);
      check({name, "_ready_drop"}, ready, 0);
      wait_build(name, n);
   endtask

   task automatic read_cell(input string name, input int x, input int y, input int exp);
      @(posedge clk);
      #1;
      rx = 6'(x);
      ry = 5'(y);
      @(posedge clk);
      @(negedge clk);
      check(name, data, exp);
   endtask

   task automatic sweep();
      for (int y = 0; y <= H; y++)
         for (int x = 0; x <= W; x++) begin
            @(posedge clk);
            #1;
            rx = 6'(x);
            ry = 5'(y);
         end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_walls();
      for (int x = 0; x < W; x++)
         for (int y = 0; y < H; y++) walls[x][y] = 1'b0;
   endtask

   initial begin
      clear_walls();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", ready, 0);
      check("reset_data", data, 255);
      check("reset_wall_x", wall_rdaddr_x, 0);
      check("reset_wall_y", wall_rdaddr_y, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Open field, pacman (5,3).
      wait_build("open", cyc);
      read_cell("open_pac", 5, 3, 0);
      read_cell("open_right", 6, 3, 1);
      read_cell("open_origin", 0, 0, 8);
`ifdef GHOST_MAP_TUNNEL_EN
      read_cell("open_corner", 15, 7, 10);
`else
      read_cell("open_corner", 15, 7, 14);
`endif
      read_cell("oor_x63", 63, 3, 255);
      read_cell("oor_x16", 16, 2, 255);
      read_cell("oor_y31", 4, 31, 255);
      read_cell("oor_y8", 4, 8, 255);
      sweep();

      // Wall column x=8 rows 0..6; the only gap is row 7.
      for (int y = 0; y < H - 1; y++) walls[8][y] = 1'b1;
      rebuild("wall", 3, 3, cyc);
      read_cell("wall_cell", 8, 3, 255);
`ifdef GHOST_MAP_TUNNEL_EN
      read_cell("wall_far", 12, 3, 7);
`else
      read_cell("wall_far", 12, 3, 17);
`endif
      sweep();

      // Pacman moves while a build is mid-scan.
      clear_walls();
      set_pac(5, 3);
      rx = 6'd2;
      ry = 5'd2;
      repeat (3 * N + 40) @(posedge clk);
      @(negedge clk);
      check("mid_build_ready", ready, 0);
      check("mid_build_data", data, 255);
      rebuild("move", 6, 3, cyc);
      read_cell("move_pac", 6, 3, 0);
      read_cell("move_old", 5, 3, 1);
      read_cell("move_origin", 0, 0, 9);
      sweep();

      rebuild("corner", 0, 0, cyc);
`ifdef GHOST_MAP_TUNNEL_EN
      read_cell("corner_edge", 15, 0, 1);
`else
      read_cell("corner_edge", 15, 0, 15);
`endif
      sweep();

      // Boxed pacman: level 0 finds nothing, so exactly one scan pass.
      walls[4][5] = 1'b1;
      walls[6][5] = 1'b1;
      walls[5][4] = 1'b1;
      walls[5][6] = 1'b1;
      rebuild("boxed", 5, 5, cyc);
      check("boxed_one_level", int'(cyc >= 3 * N && cyc <= 3 * N + 8), 1);
      read_cell("boxed_far", 7, 7, 255);
      read_cell("boxed_pac", 5, 5, 0);
      read_cell("boxed_wall", 5, 4, 255);
      check("boxed_ready_hold", ready, 1);

      // Pacman off the map: map stays all 255 and completes right after CLEAR.
      clear_walls();
      rebuild("offmap", 20, 3, cyc);
      check("offmap_fast", int'(cyc <= N + 8), 1);
      read_cell("offmap_origin", 0, 0, 255);
      read_cell("offmap_cell", 5, 3, 255);
      sweep();

      // Reset during a scan, with a simultaneous pacman change.
      set_pac(2, 2);
      repeat (N + 60) @(posedge clk);
      #1;
      reset = 1'b1;
      px = 6'd7;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_ready", ready, 0);
      check("rst_mid_data", data, 255);
      check("rst_mid_wall_x", wall_rdaddr_x, 0);
      check("rst_mid_wall_y", wall_rdaddr_y, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      wait_build("after_rst", cyc);
      read_cell("after_rst_pac", 7, 2, 0);
      read_cell("after_rst_origin", 0, 0, 9);
      sweep();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ghost_dist_map_builder.md
GHOST_DIST_MAP_BUILDER -- requirements
Module: ghost_dist_map_builder

Interface
REQ-001 SHALL have parameter GRID_W, default 40, meaning map width in cells.
REQ-002 SHALL have parameter GRID_H, default 30, meaning map height in cells.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high; clock CLOCK_50.
REQ-005 SHALL have port curr_pacman_x  input  6  pacman cell column.
REQ-006 SHALL have port curr_pacman_y  input  5  pacman cell row.
REQ-007 SHALL have port wall_rdaddr_x  output  6  wall-map read column.
REQ-008 SHALL have port wall_rdaddr_y  output  5  wall-map read row.
REQ-009 SHALL have port wall_data  input  1  wall bit (1 = wall), valid one cycle after wall_rdaddr.
REQ-010 SHALL have port rdaddr_x  input  6  ghost-side distance read column.
REQ-011 SHALL have port rdaddr_y  input  5  ghost-side distance read row.
REQ-012 SHALL have port data  output  8  distance at rdaddr, registered, one-cycle latency.
REQ-013 SHALL have port ready  output  1  high while the whole map is valid for current pacman location.

Function
REQ-014 SHALL hold an internal GRID_W x GRID_H array of 8-bit distances; 0 = pacman cell, 255 = wall/unreachable/out-of-range.
REQ-015 SHALL implement FSM states IDLE, CLEAR, SEED, SCAN_ADDR, SCAN_EVAL, LEVEL_END, DONE.
REQ-016 IDLE -> CLEAR when latched pacman position differs from inputs, or on first cycle after reset; latch inputs on that transition.
REQ-017 CLEAR SHALL write 255 to one cell per cycle in raster order (x fastest), GRID_W*GRID_H cycles, then -> SEED.
REQ-018 SEED SHALL write 0 to pacman cell, set level L=0, clear changed flag, -> SCAN_ADDR at cell (0,0); if pacman out of range (x>=GRID_W or y>=GRID_H), skip to DONE with map all 255.
REQ-019 SCAN_ADDR SHALL drive wall_rdaddr = current cell, -> SCAN_EVAL.
REQ-020 SCAN_EVAL SHALL write L+1 to the cell and set changed iff wall_data=0, cell value=255, and any in-range 4-neighbour equals L; then advance raster cell -> SCAN_ADDR, or after last cell -> LEVEL_END.
REQ-021 Cells written L+1 SHALL NOT seed further updates within the same level (exact BFS).
REQ-022 LEVEL_END SHALL -> DONE if changed=0 or L+1=253; else L++, clear changed, -> SCAN_ADDR at (0,0).
REQ-023 DONE SHALL assert ready next cycle and -> CLEAR (re-latching) when pacman inputs change; otherwise hold.
REQ-024 ready SHALL be 0 in every state except DONE and SHALL drop the cycle after a pacman change is detected.
REQ-025 Pacman change in any build state SHALL abort and restart at CLEAR with the new position next cycle.
REQ-026 data SHALL be 255 when ready=0, or rdaddr_x>=GRID_W, or rdaddr_y>=GRID_H (covers 0-1 wrap to 63/31); else stored value.
REQ-027 wall_rdaddr SHALL hold its last value outside SCAN_ADDR.

Reset
REQ-028 On reset: state IDLE, ready=0, data=255, wall_rdaddr=0, latched pacman = (63,31) forcing a build; array contents are don't-care (rebuilt by CLEAR).
REQ-029 Reset SHALL win over any simultaneous pacman change or build activity.

Configuration
REQ-030 Macro GHOST_MAP_TUNNEL_EN: when defined, the left neighbour of x=0 is x=GRID_W-1 and vice versa in the same row (horizontal tunnel); when undefined, columns 0 and GRID_W-1 are hard edges. Vertical edges are hard in both cases; REQ-026 is unchanged.

Verification
REQ-031 No walls, pacman (20,20), reset released -> after ready: read (20,20)=0, (21,20)=1, (0,0)=40, (39,29)=28.
REQ-032 Ready map, read (63,13) and (40,5) -> data=255 one cycle later; read during build -> 255 with ready=0.
REQ-033 Walls x=10, y=0..28, pacman (5,5) -> (10,5)=255, (15,5)=58 (route via row 29).
REQ-034 Pacman moves (20,20)->(21,20) mid-SCAN -> ready stays 0, final (21,20)=0, (20,20)=1.
REQ-035 No walls, pacman (0,0) -> (39,0)=1 with GHOST_MAP_TUNNEL_EN, 39 without.
REQ-036 Pacman boxed by walls at (4,5),(6,5),(5,4),(5,6) -> (7,7)=255, (5,5)=0, ready=1 after level 0 with changed=0.
